// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//   Single-port word memory behind a valid/ready request/response handshake.
//   Exactly one request is outstanding at a time. The FSM walks IDLE -> (WAIT)
//   -> RESP. The memory access (write commit or read capture) happens on the
//   clock edge that enters RESP.
//
//   Optional feature (compile-time macro): MEM_PORT_MISALIGN_TRAP_EN
//     defined   : misaligned accesses fault (rsp_err=1, no write, rdata=0)
//     undefined : low byte-offset address bits are ignored
//
// Parameters
//   XLEN        data/address width (32 or 64)
//   DEPTH       storage depth in XLEN-bit words (power of two)
//   WAIT_STATES extra cycles between accept and response (0..15)
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  request present          req_ready  block can accept a request
//   req_we     1=write, 0=read          req_addr   byte address
//   req_wdata  lane-aligned write data  req_be     byte-lane write enables
//   rsp_valid  response present         rsp_ready  requester takes response
//   rsp_rdata  read data (0 on write/error)
//   rsp_err    access faulted
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int NB     = XLEN / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = OFF_W + IDX_W;
  localparam bit NO_WAIT = (WAIT_STATES == 32'sd0);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 32'sd0) ? 4'(WAIT_STATES - 32'sd1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              lat_we_r;
  logic [XLEN-1:0]   lat_addr_r;
  logic [XLEN-1:0]   lat_wdata_r;
  logic [NB-1:0]     lat_be_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [XLEN-1:0]   rsp_rdata_r;
  logic              rsp_err_r;

  logic [XLEN-1:0]   mem_r [DEPTH];

  logic              acc_we_s;
  logic [XLEN-1:0]   acc_addr_s;
  logic [XLEN-1:0]   acc_wdata_s;
  logic [NB-1:0]     acc_be_s;
  logic [IDX_W-1:0]  idx_s;
  logic              range_err_s;
  logic              misalign_s;
  logic              acc_err_s;
  logic              enter_resp_s;
  logic              commit_s;
  logic [XLEN-1:0]   rdata_nxt_s;

`ifdef MEM_PORT_MISALIGN_TRAP_EN
  // Reads and empty-lane writes must be word aligned. Other writes must start
  // at the lowest enabled lane, and that lane must sit on a boundary of the
  // power-of-two size covering the lowest..highest enabled span.
  function automatic logic misaligned(input logic we, input logic [OFF_W-1:0] off,
                                      input logic [NB-1:0] be);
    int   lo;
    int   hi;
    int   size;
    logic bad;
    lo   = 0;
    hi   = 0;
    size = 1;
    for (int i = NB - 1; i >= 0; i--) begin
      if (be[i]) lo = i;
    end
    for (int i = 0; i < NB; i++) begin
      if (be[i]) hi = i;
    end
    if (!we || (be == '0)) begin
      bad = (off != '0);
    end else begin
      for (int k = 0; k < OFF_W; k++) begin
        if (size < (hi - lo + 1)) size = size * 2;
      end
      bad = (int'(off) != lo) || ((lo & (size - 1)) != 0);
    end
    return bad;
  endfunction
`endif

  // Access fields come straight from the request in IDLE (zero-wait path),
  // otherwise from the latched copy; derive index, faults and next response.
  always_comb begin
    if (state_r == S_IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
    end else begin
      acc_we_s    = lat_we_r;
      acc_addr_s  = lat_addr_r;
      acc_wdata_s = lat_wdata_r;
      acc_be_s    = lat_be_r;
    end

    idx_s       = acc_addr_s[ADDR_W-1:OFF_W];
    range_err_s = |acc_addr_s[XLEN-1:ADDR_W];
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    misalign_s  = misaligned(acc_we_s, acc_addr_s[OFF_W-1:0], acc_be_s);
`else
    misalign_s  = 1'b0;
`endif
    acc_err_s   = range_err_s | misalign_s;

    case (state_r)
      S_IDLE:  enter_resp_s = req_valid && NO_WAIT;
      S_WAIT:  enter_resp_s = (cnt_r == 4'd0);
      default: enter_resp_s = 1'b0;
    endcase

    // reset gate keeps a request presented during reset from writing
    commit_s = enter_resp_s && acc_we_s && !acc_err_s && !reset;

    if (acc_we_s || acc_err_s) begin
      rdata_nxt_s = '0;
    end else begin
      rdata_nxt_s = mem_r[idx_s];
    end
  end

`ifndef MEM_PORT_MISALIGN_TRAP_EN
  // Byte-offset bits select nothing when the trap is disabled.
  logic unused_off_s;
  assign unused_off_s = ^acc_addr_s[OFF_W-1:0];
`endif

  // Storage array: byte-lane write on the edge entering RESP; never reset.
  always_ff @(posedge clock) begin
    if (commit_s) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be_s[i]) mem_r[idx_s][i*8 +: 8] <= acc_wdata_s[i*8 +: 8];
      end
    end
  end

  // Control FSM with request latch and registered handshake/response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      lat_we_r    <= 1'b0;
      lat_addr_r  <= '0;
      lat_wdata_r <= '0;
      lat_be_r    <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            lat_we_r    <= req_we;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
            lat_be_r    <= req_be;
            req_ready_r <= 1'b0;
            if (NO_WAIT) begin
              state_r     <= S_RESP;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= rdata_nxt_s;
              rsp_err_r   <= acc_err_s;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= S_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rdata_nxt_s;
            rsp_err_r   <= acc_err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          // ready only returns after the completing edge, so no request can
          // be accepted in the same cycle a response completes
          if (rsp_ready) begin
            state_r     <= S_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= 4'd0;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= '0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;

  logic clk;
  logic rst;

  // instance with WAIT_STATES=0
  logic        v0, rdy0, we0, rv0, rr0, er0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  be0;

  // instance with WAIT_STATES=3
  logic        v3, rdy3, we3, rv3, rr3, er3;
  logic [31:0] addr3, wd3, rd3;
  logic [3:0]  be3;

  int checks;
  int passed;

  logic        vs, es, er, ia;
  logic [31:0] rd;
  logic [31:0] held;

  mem_port_ctrl #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clock(clk), .reset(rst),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_addr(addr0),
    .req_wdata(wd0), .req_be(be0),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(er0)
  );

  mem_port_ctrl #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .clock(clk), .reset(rst),
    .req_valid(v3), .req_ready(rdy3), .req_we(we3), .req_addr(addr3),
    .req_wdata(wd3), .req_be(be3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_rdata(rd3), .rsp_err(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full access on the zero-wait instance; observed values returned.
  task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic valid_seen,
                      output logic [31:0] rdata, output logic err, output logic idle_after);
    @(negedge clk);
    v0 = 1'b1; we0 = w; addr0 = a; wd0 = d; be0 = b; rr0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; we0 = 1'b0;
    valid_seen = rv0; rdata = rd0; err = er0;
    @(posedge clk); #1;
    idle_after = rdy0 & ~rv0;
  endtask

  // One full access on the 3-wait instance; early flags any premature rsp_valid.
  task automatic acc3(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic early, output logic valid_seen,
                      output logic [31:0] rdata, output logic err, output logic idle_after);
    @(negedge clk);
    v3 = 1'b1; we3 = w; addr3 = a; wd3 = d; be3 = b; rr3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0; we3 = 1'b0;
    early = rv3;
    repeat (2) begin
      @(posedge clk); #1;
      early = early | rv3;
    end
    @(posedge clk); #1;
    valid_seen = rv3; rdata = rd3; err = er3;
    @(posedge clk); #1;
    idle_after = rdy3 & ~rv3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy0 !== 1'b1) $display("FAIL rst_ready0: got %b want 1", rdy0); else passed++;
    checks++; if (rv0 !== 1'b0) $display("FAIL rst_valid0: got %b want 0", rv0); else passed++;
    checks++; if (rd0 !== 32'h0) $display("FAIL rst_rdata0: got %h want 0", rd0); else passed++;
    checks++; if (er0 !== 1'b0) $display("FAIL rst_err0: got %b want 0", er0); else passed++;
    checks++; if (rv3 !== 1'b0) $display("FAIL rst_valid3: got %b want 0", rv3); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rdy0, rdy3} !== 2'b11) $display("FAIL rst_ready_after: got %b want 11", {rdy0, rdy3}); else passed++;
  endtask

  task automatic test_basic_rw();
    acc0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, vs, rd, er, ia);
    checks++; if (vs !== 1'b1) $display("FAIL wr_latency: rsp_valid %b want 1", vs); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL wr_rdata: got %h want 0", rd); else passed++;
    checks++; if (er !== 1'b0) $display("FAIL wr_err: got %b want 0", er); else passed++;
    checks++; if (ia !== 1'b1) $display("FAIL wr_idle: got %b want 1", ia); else passed++;
    acc0(1'b0, 32'h10, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (vs !== 1'b1) $display("FAIL rd_latency: rsp_valid %b want 1", vs); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else passed++;
    checks++; if (er !== 1'b0) $display("FAIL rd_err: got %b want 0", er); else passed++;
  endtask

  task automatic test_byte_lanes();
    acc0(1'b1, 32'h10, 32'h000000AA, 4'h1, vs, rd, er, ia);
    acc0(1'b0, 32'h10, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (rd !== 32'hDEADBEAA) $display("FAIL lane0: got %h want deadbeaa", rd); else passed++;
    acc0(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, vs, rd, er, ia);
    checks++; if (er !== 1'b0) $display("FAIL be0_err: got %b want 0", er); else passed++;
    acc0(1'b0, 32'h10, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (rd !== 32'hDEADBEAA) $display("FAIL be0_noop: got %h want deadbeaa", rd); else passed++;
    acc0(1'b1, 32'h12, 32'h11220000, 4'hC, vs, rd, er, ia);
    checks++; if (er !== 1'b0) $display("FAIL upper_err: got %b want 0", er); else passed++;
    acc0(1'b0, 32'h10, 32'h0, 4'hF, vs, rd, er, ia);
    checks++; if (rd !== 32'h1122BEAA) $display("FAIL upper_lanes: got %h want 1122beaa", rd); else passed++;
  endtask

  task automatic test_range();
    acc0(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, vs, rd, er, ia);
    acc0(1'b0, 32'h1000, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (er !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", er); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL oor_rd_data: got %h want 0", rd); else passed++;
    acc0(1'b1, 32'h1000, 32'h11111111, 4'hF, vs, rd, er, ia);
    checks++; if (er !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", er); else passed++;
    acc0(1'b0, 32'h0, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (rd !== 32'hCAFEF00D) $display("FAIL oor_no_write: got %h want cafef00d", rd); else passed++;
    acc0(1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, vs, rd, er, ia);
    acc0(1'b0, 32'hFFC, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) $display("FAIL last_word: got %h/%b want a5a5a5a5/0", rd, er); else passed++;
    acc0(1'b0, 32'h80000010, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (er !== 1'b1) $display("FAIL msb_err: got %b want 1", er); else passed++;
  endtask

  task automatic test_misalign();
    acc0(1'b0, 32'h12, 32'h0, 4'h0, vs, rd, er, ia);
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1) $display("FAIL mis_err: got %b want 1", er); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL mis_data: got %h want 0", rd); else passed++;
`else
    checks++; if (er !== 1'b0) $display("FAIL mis_err: got %b want 0", er); else passed++;
    checks++; if (rd !== 32'h1122BEAA) $display("FAIL mis_data: got %h want 1122beaa", rd); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wd0 = 32'h5555AAAA; be0 = 4'hF; rr0 = 1'b1;
    @(posedge clk); #1;
    checks++; if ({rv0, rdy0} !== 2'b10) $display("FAIL b2b_first: valid/ready %b want 10", {rv0, rdy0}); else passed++;
    we0 = 1'b0; be0 = 4'h0;
    @(posedge clk); #1;
    checks++; if ({rv0, rdy0} !== 2'b01) $display("FAIL b2b_gap: valid/ready %b want 01", {rv0, rdy0}); else passed++;
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b1) $display("FAIL b2b_second_valid: got %b want 1", rv0); else passed++;
    checks++; if (rd0 !== 32'h5555AAAA) $display("FAIL b2b_raw: got %h want 5555aaaa", rd0); else passed++;
    v0 = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rv0, rdy0} !== 2'b01) $display("FAIL b2b_end: valid/ready %b want 01", {rv0, rdy0}); else passed++;
  endtask

  task automatic test_wait_states();
    acc3(1'b1, 32'h40, 32'h0BADCAFE, 4'hF, es, vs, rd, er, ia);
    checks++; if (es !== 1'b0) $display("FAIL ws_early: got %b want 0", es); else passed++;
    checks++; if (vs !== 1'b1) $display("FAIL ws_latency: got %b want 1", vs); else passed++;
    checks++; if (ia !== 1'b1) $display("FAIL ws_idle: got %b want 1", ia); else passed++;
    // read with rsp_ready held low for four response cycles
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b0; addr3 = 32'h40; be3 = 4'h0; rr3 = 1'b0;
    @(posedge clk); #1;
    v3 = 1'b0;
    checks++; if ({rv3, rdy3} !== 2'b00) $display("FAIL ws_wait: valid/ready %b want 00", {rv3, rdy3}); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rv3 !== 1'b0) $display("FAIL ws_pre: got %b want 0", rv3); else passed++;
    @(posedge clk); #1;
    checks++; if (rv3 !== 1'b1) $display("FAIL ws_valid_at4: got %b want 1", rv3); else passed++;
    checks++; if (rd3 !== 32'h0BADCAFE) $display("FAIL ws_rdata: got %h want 0badcafe", rd3); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if ({rv3, rdy3, rd3} !== {2'b10, 32'h0BADCAFE}) $display("FAIL ws_stall%0d: valid/ready %b%b rdata %h", k, rv3, rdy3, rd3); else passed++;
    end
    rr3 = 1'b1;
    @(posedge clk); #1;
    checks++; if ({rv3, rdy3} !== 2'b01) $display("FAIL ws_release: valid/ready %b want 01", {rv3, rdy3}); else passed++;
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wd0 = 32'h01020304; be0 = 4'hF; rr0 = 1'b0;
    @(posedge clk); #1;
    v0 = 1'b0; we0 = 1'b0;
    checks++; if (rv0 !== 1'b1) $display("FAIL rresp_valid: got %b want 1", rv0); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({rv0, rdy0} !== 2'b01) $display("FAIL rresp_drop: valid/ready %b want 01", {rv0, rdy0}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    acc0(1'b0, 32'h30, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (rd !== 32'h01020304) $display("FAIL rresp_kept: got %h want 01020304", rd); else passed++;
    acc0(1'b0, 32'h0, 32'h0, 4'h0, vs, rd, er, ia);
    checks++; if (rd !== 32'hCAFEF00D) $display("FAIL rresp_storage: got %h want cafef00d", rd); else passed++;
  endtask

  task automatic test_reset_in_wait();
    acc3(1'b1, 32'h20, 32'h77777777, 4'hF, es, vs, rd, er, ia);
    @(negedge clk);
    v3 = 1'b1; we3 = 1'b1; addr3 = 32'h20; wd3 = 32'h12345678; be3 = 4'hF; rr3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0; we3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if ({rv3, rdy3} !== 2'b01) $display("FAIL rwait_in_reset: valid/ready %b want 01", {rv3, rdy3}); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rv3, rdy3} !== 2'b01) $display("FAIL rwait_after: valid/ready %b want 01", {rv3, rdy3}); else passed++;
    acc3(1'b0, 32'h20, 32'h0, 4'h0, es, vs, rd, er, ia);
    checks++; if (rd !== 32'h77777777) $display("FAIL rwait_aborted: got %h want 77777777", rd); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1'b1;
    v0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wd0 = 32'h0; be0 = 4'h0; rr0 = 1'b0;
    v3 = 1'b0; we3 = 1'b0; addr3 = 32'h0; wd3 = 32'h0; be3 = 4'h0; rr3 = 1'b0;
    held = 32'h0;
    test_reset();
    test_basic_rw();
    test_byte_lanes();
    test_range();
    test_misalign();
    test_back_to_back();
    test_wait_states();
    test_reset_in_resp();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
